// File: rtl/ones_pattern_gen.sv
// Emits every 3-bit pattern {a,b,c} whose popcount equals the requested count,
// one per output handshake, scanning candidate indices in a fixed direction.
module ones_pattern_gen #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       y1,
  input  logic       y0,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [1:0] o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds until transfer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cnt;
  logic [2:0] r_idx;
  logic [2:0] r_pat;
  logic       r_valid;
  logic       r_last;
  logic       w_match;
  logic       w_no_more;
  logic [2:0] w_idx_step;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  assign w_match    = (popcount3(r_idx) == r_cnt);
  assign w_idx_step = DESCENDING ? (r_idx - 3'd1) : (r_idx + 3'd1);

  // Look ahead past the current candidate so the last pattern is flagged
  // at the time it is registered, not one handshake later.
  always_comb begin
    w_no_more = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((DESCENDING ? (j < int'(r_idx)) : (j > int'(r_idx))) &&
          (popcount3(3'(j)) == r_cnt))
        w_no_more = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = ST_SCAN;
      ST_SCAN: if (w_match) w_next = ST_EMIT;
      ST_EMIT: if (out_ready) w_next = r_last ? ST_IDLE : ST_SCAN;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_idx   <= 3'd0;
      r_pat   <= 3'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cnt <= {y1, y0};
            r_idx <= DESCENDING ? 3'd7 : 3'd0;
          end
        end
        ST_SCAN: begin
          if (w_match) begin
            r_pat   <= r_idx;
            r_last  <= w_no_more;
            r_valid <= 1'b1;
          end else begin
            r_idx <= w_idx_step;
          end
        end
        ST_EMIT: begin
          // out_valid is always high here, so out_ready alone completes a transfer.
          if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (!r_last) r_idx <= w_idx_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign a           = r_pat[2];
  assign b           = r_pat[1];
  assign c           = r_pat[0];
  assign out_valid   = r_valid;
  assign out_last    = r_last;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: ascending and descending instances, a reference
// pattern list model feeding an expected queue, and a monitor on each output port.
module tb_ones_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, y1, y0;
  logic [1:0] a, b, c, out_valid, out_ready, out_last;
  logic [1:0] dbg0, dbg1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Entry: {requested count[1:0], pattern[2:0], last}
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  int         rdy_mode[2];
  int         st_cnt[2];
  logic       pv[2];
  logic       ph[2];
  logic [2:0] hp[2];
  logic       hl[2];
  logic [7:0] seen[2];
  int         emitted[2];
  int         last_hs[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ones_pattern_gen #(.DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst(rst), .y1(y1[0]), .y0(y0[0]), .req_valid(req_valid[0]),
    .req_ready(req_ready[0]), .a(a[0]), .b(b[0]), .c(c[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]), .o_dbg_state(dbg0)
  );

  ones_pattern_gen #(.DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst(rst), .y1(y1[1]), .y0(y0[1]), .req_valid(req_valid[1]),
    .req_ready(req_ready[1]), .a(a[1]), .b(b[1]), .c(c[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]), .o_dbg_state(dbg1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [1:0] ones_counter(input logic [2:0] p);
    return {1'b0, p[2]} + {1'b0, p[1]} + {1'b0, p[0]};
  endfunction

  // Reference: walk all 8 values in scan order, keep those with the right popcount.
  task automatic model_push(input int d, input logic [1:0] cnt, output int k);
    int hits[$];
    k = -1;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = (d == 1) ? (7 - i) : i;
      if ($countones(v[2:0]) == int'(cnt)) begin
        if (k < 0) k = i;
        hits.push_back(v);
      end
    end
    foreach (hits[n]) begin
      logic [5:0] e;
      e = {cnt, 3'(hits[n]), (n == hits.size() - 1)};
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic drive_req(input int d, input logic [1:0] cnt, input bit measure, input bit b2b);
    int n;
    int k;
    int acc;
    n = 0;
    while (!req_ready[d] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[d]) begin
      chk("req_ready_timeout", 0, 1);
    end else begin
      model_push(d, cnt, k);
      req_valid[d] = 1'b1;
      y1[d] = cnt[1];
      y0[d] = cnt[0];
      acc = cyc;
      if (b2b) chk("b2b_accept_cycle", acc, last_hs[d] + 1);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      y1[d] = 1'($urandom_range(0, 1));
      y0[d] = 1'($urandom_range(0, 1));
      if (measure) begin
        n = 1;
        while (!out_valid[d] && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk("first_valid_latency", n, 2 + k);
      end
    end
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!(req_ready[d] && qsize(d) == 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sequence_complete", (req_ready[d] && qsize(d) == 0) ? 1 : 0, 1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_req_ready0"}, int'(req_ready[0]), 1);
    chk({tag, "_out_valid0"}, int'(out_valid[0]), 0);
    chk({tag, "_out_last0"},  int'(out_last[0]), 0);
    chk({tag, "_abc0"},       int'({a[0], b[0], c[0]}), 0);
    chk({tag, "_state0"},     int'(dbg0), 0);
    chk({tag, "_req_ready1"}, int'(req_ready[1]), 1);
    chk({tag, "_out_valid1"}, int'(out_valid[1]), 0);
    chk({tag, "_abc1"},       int'({a[1], b[1], c[1]}), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic mon(input int d);
    logic [2:0] pat;
    logic [5:0] e;
    pat = {a[d], b[d], c[d]};
    if (rst) begin
      pv[d] = 1'b0;
      ph[d] = 1'b0;
    end else begin
      if (pv[d] && !ph[d] && out_valid[d]) begin
        chk("hold_pattern", int'(pat), int'(hp[d]));
        chk("hold_last", int'(out_last[d]), int'(hl[d]));
      end
      if (out_valid[d] && out_ready[d]) begin
        if (qsize(d) == 0) begin
          chk("unexpected_output", int'(pat) + 1, 0);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          chk("pattern", int'(pat), int'(e[3:1]));
          chk("last", int'(out_last[d]), int'(e[0]));
          chk("loopback_count", int'(ones_counter(pat)), int'(e[5:4]));
          seen[d][pat] = 1'b1;
          emitted[d]++;
          if (out_last[d]) last_hs[d] = cyc;
        end
      end
      pv[d] = out_valid[d];
      ph[d] = out_valid[d] && out_ready[d];
      hp[d] = pat;
      hl[d] = out_last[d];
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Consumer: 0 always ready, 1 random, 2 stall 5 cycles per pattern, 3 never ready.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rdy_mode[d])
        0: out_ready[d] = 1'b1;
        1: out_ready[d] = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid[d]) begin
            if (st_cnt[d] < 5) begin
              out_ready[d] = 1'b0;
              st_cnt[d]++;
            end else begin
              out_ready[d] = 1'b1;
              st_cnt[d] = 0;
            end
          end else begin
            out_ready[d] = 1'b0;
            st_cnt[d] = 0;
          end
        end
        default: out_ready[d] = 1'b0;
      endcase
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    y1 = 2'b00;
    y0 = 2'b00;
    out_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      rdy_mode[d] = 0; st_cnt[d] = 0; pv[d] = 1'b0; ph[d] = 1'b0;
      hp[d] = 3'd0; hl[d] = 1'b0; seen[d] = 8'd0; emitted[d] = 0; last_hs[d] = 0;
    end
    @(posedge clk); #1;
    do_reset("reset_init");

    // All counts in both directions; every 3-bit value must appear exactly once.
    for (int d = 0; d < 2; d++) begin
      seen[d] = 8'd0;
      emitted[d] = 0;
      for (int cnt = 0; cnt < 4; cnt++) begin
        drive_req(d, 2'(cnt), 1'b1, 1'b0);
        wait_done(d);
      end
      chk("loopback_all_values", int'(seen[d]), 255);
      chk("loopback_total", emitted[d], 8);
    end

    // Backpressure on count 2.
    for (int d = 0; d < 2; d++) begin
      rdy_mode[d] = 2;
      emitted[d] = 0;
      drive_req(d, 2'd2, 1'b1, 1'b0);
      wait_done(d);
      chk("backpressure_count", emitted[d], 3);
      rdy_mode[d] = 0;
    end

    // Request while busy is ignored.
    drive_req(0, 2'd1, 1'b1, 1'b0);
    req_valid[0] = 1'b1;
    y1[0] = 1'b1;
    y0[0] = 1'b1;
    chk("busy_req_ready", int'(req_ready[0]), 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_done(0);

    // Back-to-back requests right after the last handshake.
    drive_req(0, 2'd1, 1'b1, 1'b0);
    drive_req(0, 2'd2, 1'b1, 1'b1);
    wait_done(0);
    drive_req(1, 2'd3, 1'b1, 1'b0);
    drive_req(1, 2'd0, 1'b1, 1'b1);
    wait_done(1);

    // Reset in IDLE, mid-SCAN and mid-EMIT.
    do_reset("rst_idle");
    drive_req(0, 2'd3, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("scan_state", int'(dbg0), 1);
    do_reset("rst_scan");
    rdy_mode[0] = 3;
    drive_req(0, 2'd2, 1'b1, 1'b0);
    chk("emit_valid_before_reset", int'(out_valid[0]), 1);
    do_reset("rst_emit");
    rdy_mode[0] = 0;
    drive_req(0, 2'd1, 1'b1, 1'b0);
    wait_done(0);

    // Random requests with random consumer behaviour.
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 1);
      rdy_mode[d] = $urandom_range(0, 2);
      drive_req(d, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      wait_done(d);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queue0_empty", exp_q0.size(), 0);
    chk("queue1_empty", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_pattern_gen.md
# ones_pattern_gen

Sequential generator for the 3-input ones-counter interface, working in the opposite direction. It accepts a requested ones count on `y1`,`y0` and emits every 3-bit pattern `{a,b,c}` with exactly that many ones, one pattern per output handshake. It drives the `a`,`b`,`c` side of a ones-counter for exhaustive self-checking. It sits between a test or control sequencer and the counter datapath.

## Interface
- `DESCENDING`, default 0: 0 = scan candidates 0→7; 1 = scan 7→0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `y1`  in  1  requested count, MSB; sampled only on request handshake.
- `y0`  in  1  requested count, LSB.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `a`  out  1  pattern MSB (`{a,b,c}` = candidate index).
- `b`  out  1  pattern middle bit.
- `c`  out  1  pattern LSB.
- `out_valid`  out  1  `{a,b,c}` holds a valid pattern.
- `out_ready`  in  1  consumer accepts the pattern.
- `out_last`  out  1  current pattern is the final one for this request; qualified by `out_valid`.

## Operation
- States: IDLE, SCAN, EMIT.
- IDLE: `req_ready`=1. When `req_valid`&`req_ready`, register `cnt_q`={y1,y0}. Load `idx_q` with 0, or 7 if DESCENDING. Next state is SCAN.
- SCAN: one candidate per cycle, `match = (popcount(idx_q) == cnt_q)`, with popcount 2 bits wide (0..3).
  - On match: register `{a,b,c}`=idx_q and `out_last`=`no_more`, set `out_valid`, go to EMIT.
  - On no match: step `idx_q` (+1, or −1 if DESCENDING) and stay in SCAN.
  - `idx_q` never wraps in SCAN, because every count 0..3 has a match at or before the scan end.
- `no_more`: no index strictly beyond `idx_q` in scan direction has popcount == `cnt_q`. It is computed combinationally from `idx_q` and `cnt_q`.
- EMIT: `out_valid`=1. `a`,`b`,`c`,`out_last` stay stable while `out_ready`=0. On `out_valid`&`out_ready`:
  - if `out_last`=1: clear `out_valid` and `out_last`, go to IDLE;
  - else step `idx_q` and go to SCAN.
- Sequences, ascending:
  - count 0 → 000;
  - count 1 → 001, 010, 100;
  - count 2 → 011, 101, 110;
  - count 3 → 111.
  - DESCENDING emits the same sets in reverse order.
- `req_valid` while not in IDLE is ignored. `y1`/`y0` changes after capture have no effect.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Timing
- Reset (sync, `rst`=1 at a rising edge), next cycle:
  - state IDLE, `req_ready`=1;
  - `a`=`b`=`c`=0, `out_valid`=0, `out_last`=0;
  - `idx_q`=0, `cnt_q`=0.
- `rst` overrides everything, including mid-SCAN or mid-EMIT. The sequence is abandoned and no partial output remains.
- Request accepted in cycle T: SCAN checks the first candidate in T+1. A match at scan position k (0-based) gives `out_valid`=1 from cycle T+2+k.
  - Ascending: count 0 valid at T+2; count 3 valid at T+9.
- Handshake at cycle H (not last), next match m scan positions later: `out_valid`=0 for cycles H+1..H+m, then `out_valid`=1 at H+m+1.
  - Minimum gap is 1 idle cycle; there is no back-to-back output.
- Last handshake at H: IDLE in H+1 with `req_ready`=1. A new request can be accepted in H+1.
- `req_ready` is a decode of state only, with no combinational path from `req_valid`.
- `out_valid`, `out_last`, `a`, `b`, `c` are registered outputs.

## Test plan
- **Reset mid-operation.** Assert `rst` during IDLE, then during SCAN, then during EMIT with `out_valid`=1. Required next cycle:
  - `req_ready`=1;
  - `out_valid`=0, `out_last`=0;
  - `{a,b,c}`=000.
- **All counts, ascending.** Request each count with `out_ready` held 1:
  - count 0 → 000 last, valid at T+2;
  - count 1 → 001, 010, 100 (last on 100);
  - count 2 → 011, 101, 110;
  - count 3 → 111 last, valid at T+9.
- **Backpressure.** Count 2 with `out_ready`=0 for 5 cycles on each pattern: `{a,b,c}` and `out_last` are held stable while `out_valid`=1. Exactly three patterns are emitted, with no duplicates or drops.
- **Request while busy and back-to-back requests.**
  - Pulse `req_valid` with count 3 during a count-1 sequence: it is ignored (`req_ready`=0) and the sequence completes unchanged.
  - A new request presented in the cycle after the last handshake is accepted that cycle.
- **DESCENDING=1.**
  - count 1 → 100, 010, 001;
  - count 2 → 110, 101, 011;
  - count 0 → 000 valid at T+9.
- **Loopback.** Feed `{a,b,c}` into a reference ones-counter and check `{y1,y0}` out equals the requested count on every accepted pattern. Total patterns across counts 0..3 = 8, each 3-bit value exactly once.
